// File: rtl/dac_update_sched_if.sv
// Host/serializer-side signal bundle of the DAC update scheduler.
// The master side is the host (plus the serializer sink); the slave side is the scheduler.
interface dac_update_sched_if;
    logic         WR_EN;
    logic [6:0]   WR_ADDR;
    logic [7:0]   WR_DATA;
    logic         UPDATE;
    logic         AUTO;
    logic [767:0] NMBR;
    logic         SER_RESET_N;
    logic         SER_ACTIVE_N;
    logic         BUSY;
    logic         DONE;
    logic         WR_ERR;
    logic [15:0]  FRAME_CNT;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, UPDATE, AUTO,
        input  NMBR, SER_RESET_N, SER_ACTIVE_N, BUSY, DONE, WR_ERR, FRAME_CNT
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, UPDATE, AUTO,
        output NMBR, SER_RESET_N, SER_ACTIVE_N, BUSY, DONE, WR_ERR, FRAME_CNT
    );
endinterface

// File: rtl/dac_update_sched.sv
// Double-buffered update scheduler: host shadow bank of 96 DAC codes, packed into the
// serializer code vector, with one gated serializer frame per update request.
module dac_update_sched #(
    parameter int unsigned FRAME_LEN = 17,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic              SCLK,
    input  logic              RESET,
    dac_update_sched_if.slave bus
);

    localparam int unsigned   WORDS    = 96;
    localparam logic [7:0]    FRAME_M1 = 8'(FRAME_LEN - 1);
    localparam logic [7:0]    GAP_M1   = 8'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP
    } state_t;

    state_t         state_reg;
    logic [7:0]     cnt_reg;
    logic           pending_reg;
    logic           dirty_reg;
    logic           ser_reset_n_reg;
    logic           ser_active_n_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           wr_err_reg;
    logic [15:0]    frame_cnt_reg;
    logic [767:0]   nmbr_reg;
    logic [767:0]   shadow_vec;

    logic           wr_ok;
    logic           wr_bad;
    logic           start_frame;

    assign wr_ok       = bus.WR_EN && (bus.WR_ADDR <= 7'd95);
    assign wr_bad      = bus.WR_EN && (bus.WR_ADDR > 7'd95);
    assign start_frame = (state_reg == ST_IDLE) &&
                         (pending_reg || bus.UPDATE || (bus.AUTO && dirty_reg));

    // Shadow bank kept in flops: LOAD needs every word in the same cycle.
    // Each word is stored bit-reversed so its MSB lands on the lowest vector index.
    genvar gi, gb;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [7:0] word_reg;

            always_ff @(posedge SCLK or posedge RESET) begin
                if (RESET) begin
                    word_reg <= '0;
                end else if (wr_ok && (bus.WR_ADDR == 7'(gi))) begin
                    word_reg <= bus.WR_DATA;
                end
            end

            for (gb = 0; gb < 8; gb++) begin : g_bit
                assign shadow_vec[8*gi + gb] = word_reg[7 - gb];
            end
        end
    endgenerate

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            pending_reg      <= 1'b0;
            dirty_reg        <= 1'b0;
            ser_reset_n_reg  <= 1'b0;
            ser_active_n_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            wr_err_reg       <= 1'b0;
            frame_cnt_reg    <= '0;
            nmbr_reg         <= '0;
        end else begin
            ser_active_n_reg <= 1'b1;
            done_reg         <= 1'b0;
            wr_err_reg       <= wr_bad;

            // A write landing in LOAD keeps the bank dirty: its data missed this frame.
            if (wr_ok) begin
                dirty_reg <= 1'b1;
            end else if (state_reg == ST_LOAD) begin
                dirty_reg <= 1'b0;
            end

            if (start_frame) begin
                pending_reg <= 1'b0;
            end else if (bus.UPDATE) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_frame) begin
                        state_reg <= ST_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    nmbr_reg        <= shadow_vec;
                    ser_reset_n_reg <= 1'b1;
                    cnt_reg         <= FRAME_M1;
                    state_reg       <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_reg == 8'd0) begin
                        ser_reset_n_reg <= 1'b0;
                        cnt_reg         <= GAP_M1;
                        state_reg       <= ST_GAP;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg     <= ST_IDLE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.NMBR         = nmbr_reg;
    assign bus.SER_RESET_N  = ser_reset_n_reg;
    assign bus.SER_ACTIVE_N = ser_active_n_reg;
    assign bus.BUSY         = busy_reg;
    assign bus.DONE         = done_reg;
    assign bus.WR_ERR       = wr_err_reg;
    assign bus.FRAME_CNT    = frame_cnt_reg;

endmodule

// File: tb/tb_dac_update_sched.sv
// Directed and randomized bench for dac_update_sched against an array-based model
// of the shadow bank and the frame timeline.
module tb_dac_update_sched;

    localparam int FRAME_LEN = 17;
    localparam int GAP_LEN   = 2;

    logic SCLK;
    logic RESET;
    dac_update_sched_if bus();

    dac_update_sched #(.FRAME_LEN(FRAME_LEN), .GAP_LEN(GAP_LEN)) dut (
        .SCLK  (SCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    int checks;
    int failures;

    logic [7:0]   m_shadow [96];
    logic [767:0] m_nmbr;
    logic [15:0]  m_frames;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        int first;
        first = -1;
        for (int a = 95; a >= 0; a--) begin
            if (obs[8*a +: 8] !== exp[8*a +: 8]) first = a;
        end
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s first differing word %0d observed=%b expected=%b",
                   tag, first, obs[8*first +: 8], exp[8*first +: 8]);
        end
    endtask

    // Expected code vector: word a occupies bits 8a..8a+7, MSB first.
    function automatic logic [767:0] pack();
        logic [767:0] v;
        v = '0;
        for (int a = 0; a < 96; a++) begin
            for (int k = 0; k < 8; k++) begin
                v[8*a + k] = m_shadow[a][7 - k];
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 96; a++) m_shadow[a] = 8'h00;
        m_nmbr   = '0;
        m_frames = '0;
    endtask

    task automatic write(input int addr, input logic [7:0] data);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = 7'(addr);
        bus.WR_DATA = data;
        tick();
        bus.WR_EN = 1'b0;
        if (addr <= 95) m_shadow[addr] = data;
        chk_bit("wr_err", bus.WR_ERR, addr > 95);
        $display("write a=%0d d=%02h wr_err=%b", addr, data, bus.WR_ERR);
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_bit({tag, "_busy"}, bus.BUSY, 1'b0);
            chk_bit({tag, "_ser"}, bus.SER_RESET_N, 1'b0);
            chk_bit({tag, "_done"}, bus.DONE, 1'b0);
        end
    endtask

    // Called when the next edge is the one on which IDLE sees a trigger.
    // Optional write on the LOAD edge, optional write and UPDATE pulses during RUN.
    task automatic expect_frame(input string tag, input int ld_addr, input logic [7:0] ld_data,
                                input int run_addr, input logic [7:0] run_data, input int n_upd);
        logic [767:0] exp;
        int hi;
        logic wr_now, up_now;

        tick();
        bus.UPDATE = 1'b0;
        chk_bit({tag, "_load_busy"}, bus.BUSY, 1'b1);
        chk_bit({tag, "_load_ser"}, bus.SER_RESET_N, 1'b0);
        chk_vec({tag, "_load_nmbr_old"}, bus.NMBR, m_nmbr);

        exp = pack();
        if (ld_addr >= 0) begin
            bus.WR_EN   = 1'b1;
            bus.WR_ADDR = 7'(ld_addr);
            bus.WR_DATA = ld_data;
        end
        tick();
        bus.WR_EN = 1'b0;
        if (ld_addr >= 0) m_shadow[ld_addr] = ld_data;
        m_nmbr = exp;
        chk_bit({tag, "_run_ser"}, bus.SER_RESET_N, 1'b1);
        chk_vec({tag, "_run_nmbr"}, bus.NMBR, exp);

        hi = 1;
        for (int i = 0; i < 300; i++) begin
            wr_now = (run_addr >= 0) && (hi == 3);
            up_now = (hi >= 5) && (hi < 5 + 2*n_upd) && ((hi % 2) == 1);
            bus.WR_EN   = wr_now;
            bus.WR_ADDR = 7'(run_addr);
            bus.WR_DATA = run_data;
            bus.UPDATE  = up_now;
            tick();
            bus.WR_EN  = 1'b0;
            bus.UPDATE = 1'b0;
            if (wr_now) m_shadow[run_addr] = run_data;
            if (bus.SER_RESET_N !== 1'b1) break;
            hi++;
            chk_vec({tag, "_nmbr_hold"}, bus.NMBR, exp);
        end
        chk_int({tag, "_run_len"}, hi, FRAME_LEN);

        for (int g = 0; g < GAP_LEN; g++) begin
            chk_bit({tag, "_gap_ser"}, bus.SER_RESET_N, 1'b0);
            chk_bit({tag, "_gap_busy"}, bus.BUSY, 1'b1);
            chk_bit({tag, "_gap_done"}, bus.DONE, 1'b0);
            tick();
        end
        m_frames = m_frames + 16'd1;
        chk_bit({tag, "_done"}, bus.DONE, 1'b1);
        chk_bit({tag, "_idle_busy"}, bus.BUSY, 1'b0);
        chk_16({tag, "_frame_cnt"}, bus.FRAME_CNT, m_frames);
        chk_vec({tag, "_final_nmbr"}, bus.NMBR, exp);
        $display("frame %0d %s done", m_frames, tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        RESET       = 1'b1;
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = '0;
        bus.WR_DATA = '0;
        bus.UPDATE  = 1'b0;
        bus.AUTO    = 1'b0;

        // Reset values
        repeat (3) tick();
        chk_vec("rst_nmbr", bus.NMBR, '0);
        chk_bit("rst_ser", bus.SER_RESET_N, 1'b0);
        chk_bit("rst_active", bus.SER_ACTIVE_N, 1'b0);
        chk_bit("rst_busy", bus.BUSY, 1'b0);
        chk_bit("rst_done", bus.DONE, 1'b0);
        chk_bit("rst_wr_err", bus.WR_ERR, 1'b0);
        chk_16("rst_frame_cnt", bus.FRAME_CNT, 16'h0000);
        RESET = 1'b0;
        tick();
        chk_bit("active_after_rst", bus.SER_ACTIVE_N, 1'b1);
        expect_idle("idle0", 2);

        // Basic frame with end words and a non-palindromic word
        write(0, 8'hA5);
        write(95, 8'h3C);
        write(1, 8'h80);
        bus.UPDATE = 1'b1;
        expect_frame("basic", -1, 8'h00, -1, 8'h00, 0);
        chk_16("nmbr_w0", {8'h00, bus.NMBR[7:0]}, 16'h00A5);
        chk_16("nmbr_w95", {8'h00, bus.NMBR[767:760]}, 16'h003C);
        chk_16("nmbr_w1", {8'h00, bus.NMBR[15:8]}, 16'h0001);
        expect_idle("basic_after", 3);

        // AUTO start from a single write, no repeat
        bus.AUTO = 1'b1;
        write(13, 8'hFF);
        expect_frame("auto", -1, 8'h00, -1, 8'h00, 0);
        expect_idle("auto_after", 5);
        bus.AUTO = 1'b0;

        // Write and three UPDATE pulses during RUN coalesce into one follow-up frame
        bus.UPDATE = 1'b1;
        expect_frame("run_upd", -1, 8'h00, 13, 8'h00, 3);
        expect_frame("pending", -1, 8'h00, -1, 8'h00, 0);
        chk_16("nmbr_w13_clr", {8'h00, bus.NMBR[111:104]}, 16'h0000);
        expect_idle("pending_after", 4);

        // Write on the LOAD edge: old word goes out, AUTO re-fires with the new one
        bus.AUTO = 1'b1;
        write(20, 8'h11);
        expect_frame("ld_col", 20, 8'h22, -1, 8'h00, 0);
        chk_16("ld_col_old_word", {8'h00, bus.NMBR[167:160]}, 16'h0088);
        expect_frame("ld_col2", -1, 8'h00, -1, 8'h00, 0);
        chk_16("ld_col_new_word", {8'h00, bus.NMBR[167:160]}, 16'h0044);
        expect_idle("ld_col_after", 4);

        // Out-of-range writes: error pulse, no dirty, no shadow change
        write(96, 8'h5A);
        write(127, 8'hC3);
        tick();
        chk_bit("wr_err_pulse_end", bus.WR_ERR, 1'b0);
        expect_idle("bad_wr_no_auto", 4);
        bus.AUTO = 1'b0;
        bus.UPDATE = 1'b1;
        expect_frame("bad_wr_frame", -1, 8'h00, -1, 8'h00, 0);
        expect_idle("bad_wr_after", 2);

        // Randomized writes followed by an update
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 10; w++) begin
                write(int'($urandom_range(0, 127)), 8'($urandom));
            end
            bus.UPDATE = 1'b1;
            expect_frame("random", -1, 8'h00, -1, 8'h00, 0);
            expect_idle("random_after", 2);
        end

        // Reset during RUN cycle 8
        bus.UPDATE = 1'b1;
        tick();
        bus.UPDATE = 1'b0;
        tick();
        repeat (7) tick();
        chk_bit("pre_abort_ser", bus.SER_RESET_N, 1'b1);
        RESET = 1'b1;
        #2;
        chk_bit("abort_ser", bus.SER_RESET_N, 1'b0);
        chk_bit("abort_busy", bus.BUSY, 1'b0);
        chk_bit("abort_done", bus.DONE, 1'b0);
        chk_bit("abort_active", bus.SER_ACTIVE_N, 1'b0);
        chk_vec("abort_nmbr", bus.NMBR, '0);
        chk_16("abort_frame_cnt", bus.FRAME_CNT, 16'h0000);
        model_reset();
        tick();
        RESET = 1'b0;
        tick();
        chk_bit("abort_active_back", bus.SER_ACTIVE_N, 1'b1);
        expect_idle("abort_idle", 25);
        bus.UPDATE = 1'b1;
        expect_frame("post_abort", -1, 8'h00, -1, 8'h00, 0);
        expect_idle("post_abort_after", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
